// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------
// Moore controller for a shared-resource multicycle MIPS datapath. It has one
// memory, one ALU, and IR/A/B/ALUOut/Data registers. Supported instructions:
// R-type (add/sub/and/or/slt/sllv/srlv/srav), lw, sw, beq, addi and j.
// It stalls on a memory-ready handshake and traps on illegal encodings.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; also gates every strobe low
//   opcode       IR[31:26], stable from the cycle after FETCH completes
//   funct        IR[5:0]
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   iord         0 = PC address, 1 = ALUOut address
//   mem_write    memory write strobe
//   ir_write     IR load enable
//   reg_write    register file write enable
//   reg_dst      1 = rd, 0 = rt
//   mem_to_reg   1 = Data register, 0 = ALUOut
//   alu_src_a    0 = PC, 1 = A
//   alu_src_b    00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   alu_control  ALU operation code
//   pc_src       00 = ALUResult, 01 = ALUOut, 10 = jump target
//   pc_en        PC load enable
//   instr_done   one-cycle pulse on the final cycle of each instruction
//   illegal      sticky trap flag
//
// State table
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
//   DECODE | precompute branch target into ALUOut, dispatch on opcode
//   MEMADR | compute A + SignImm for lw/sw
//   MEMRD  | read data memory, wait for mem_ready
//   MEMWB  | write loaded data to rt
//   MEMWR  | write data memory, wait for mem_ready
//   EXEC   | R-type ALU operation A op B
//   ALUWB  | write ALU result to rd
//   BRANCH | compare A - B, load PC from ALUOut when equal
//   ADDIEX | compute A + SignImm
//   ADDIWB | write addi result to rt
//   JUMP   | load PC with jump target
//   TRAP   | illegal encoding seen, absorbing until reset

module multicycle_ctrl #(
    parameter logic [3:0] ADD_CODE = 4'b0010,
    parameter logic [3:0] SUB_CODE = 4'b0110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // Registered per-state control word. Qualifiers that depend on live
    // inputs (mem_ready, zero, rst_n) are kept as flags and combined at the
    // output so the word itself is a pure function of the state.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       fetch;          // ir_write and pc_en follow mem_ready
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       done;
        logic       done_on_ready;  // instr_done follows mem_ready
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
            FN_SLLV, FN_SRLV, FN_SRAV: funct_legal = 1'b1;
            default:                   funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:  alu_for_funct = ADD_CODE;
            FN_SUB:  alu_for_funct = SUB_CODE;
            FN_AND:  alu_for_funct = 4'b0000;
            FN_OR:   alu_for_funct = 4'b0001;
            FN_SLT:  alu_for_funct = 4'b0111;
            FN_SLLV: alu_for_funct = 4'b0011;
            FN_SRLV: alu_for_funct = 4'b0101;
            FN_SRAV: alu_for_funct = 4'b1000;
            default: alu_for_funct = ADD_CODE;
        endcase
    endfunction

    function automatic state_t next_state(input state_t     s,
                                          input logic [5:0] op,
                                          input logic [5:0] fn,
                                          input logic       rdy);
        case (s)
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     next_state = funct_legal(fn) ? S_EXEC : S_TRAP;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_TRAP;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but lw is a store.
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_ADDIEX: next_state = S_ADDIWB;
            S_ADDIWB: next_state = S_FETCH;
            S_JUMP:   next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c             = '0;
        c.alu_control = ADD_CODE;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req       = 1'b1;
                c.iord          = 1'b1;
                c.mem_write     = 1'b1;
                c.done_on_ready = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_for_funct(fn);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = SUB_CODE;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
                c.done        = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
                c.done     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign state_nxt = next_state(state, opcode, funct, mem_ready);

    // The control word is loaded from the state being entered, so every
    // Moore output is a flop output in the cycle it applies to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ctrl    <= decode_ctrl(S_FETCH, funct);
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            ctrl  <= decode_ctrl(state_nxt, funct);
            if (state_nxt == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Strobes are gated by rst_n so a reset mid-access can never finish a
    // write in the cycle it is asserted.
    assign mem_req    = rst_n & ctrl.mem_req;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign ir_write   = rst_n & ctrl.fetch & mem_ready;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign pc_en      = rst_n & ((ctrl.fetch & mem_ready) | ctrl.pc_write |
                                 (ctrl.branch & zero));
    assign instr_done = rst_n & (ctrl.done | (ctrl.done_on_ready & mem_ready));

    assign iord        = ctrl.iord;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_control = ctrl.alu_control;
    assign pc_src      = ctrl.pc_src;

endmodule
